// File: rtl/debounce_multicanal.sv
// Multi-channel button debouncer: 2-flop synchronizer, shared sample-tick prescaler,
// per-channel debounce and hold counters, registered press/release/long-press pulses.
module debounce_multicanal #(
  parameter int CANAIS         = 4,
  parameter int PRESCALE       = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int HOLD_TICKS     = 1000,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CANAIS-1:0] botoesEntrada,
  output logic [CANAIS-1:0] botoesFiltrados,
  output logic [CANAIS-1:0] pulsoPressao,
  output logic [CANAIS-1:0] pulsoSoltura,
  output logic [CANAIS-1:0] pulsoLongo
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int HW = $clog2(HOLD_TICKS) + 1;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0]     DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0]     HOLD_FULL  = HW'(HOLD_TICKS);
  localparam logic [CANAIS-1:0] IDLE_RAW   = (ACTIVE_LOW != 0) ? {CANAIS{1'b1}} : {CANAIS{1'b0}};

  logic [CANAIS-1:0] sync1_q, sync2_q;
  logic [CANAIS-1:0] sync_s;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_s;
  logic [DW-1:0]     deb_q [CANAIS];
  logic [DW-1:0]     deb_d [CANAIS];
  logic [HW-1:0]     hold_q [CANAIS];
  logic [HW-1:0]     hold_d [CANAIS];
  logic [CANAIS-1:0] filt_q, filt_d;
  logic [CANAIS-1:0] press_q, press_d;
  logic [CANAIS-1:0] rel_q, rel_d;
  logic [CANAIS-1:0] long_q, long_d;

  assign sync_s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // Next-state logic for prescaler, debounce/hold counters and pulse flops
  always_comb begin
    tick_s  = (presc_q == PRESC_LAST);
    presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
    filt_d  = filt_q;
    long_d  = {CANAIS{1'b0}};
    for (int i = 0; i < CANAIS; i++) begin
      deb_d[i]  = deb_q[i];
      hold_d[i] = hold_q[i];
      if (sync_s[i] == filt_q[i]) begin
        deb_d[i] = {DW{1'b0}};
      end else if (tick_s) begin
        if (deb_q[i] == DEB_LAST) begin
          filt_d[i] = sync_s[i];
          deb_d[i]  = {DW{1'b0}};
        end else begin
          deb_d[i] = deb_q[i] + DW'(1);
        end
      end else begin
        deb_d[i] = deb_q[i];
      end
      if (!filt_q[i]) begin
        hold_d[i] = {HW{1'b0}};
      end else if (tick_s && (hold_q[i] != HOLD_FULL)) begin
        hold_d[i] = hold_q[i] + HW'(1);
      end else begin
        hold_d[i] = hold_q[i];
      end
      // A release accepted on the completing tick suppresses the long-press pulse
      long_d[i] = filt_d[i] && (hold_d[i] == HOLD_FULL) && (hold_q[i] != HOLD_FULL);
    end
    press_d = filt_d & ~filt_q;
    rel_d   = ~filt_d & filt_q;
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
      presc_q <= {PW{1'b0}};
      filt_q  <= {CANAIS{1'b0}};
      press_q <= {CANAIS{1'b0}};
      rel_q   <= {CANAIS{1'b0}};
      long_q  <= {CANAIS{1'b0}};
      for (int i = 0; i < CANAIS; i++) begin
        deb_q[i]  <= {DW{1'b0}};
        hold_q[i] <= {HW{1'b0}};
      end
    end else begin
      sync1_q <= botoesEntrada;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      filt_q  <= filt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      for (int i = 0; i < CANAIS; i++) begin
        deb_q[i]  <= deb_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign botoesFiltrados = filt_q;
  assign pulsoPressao    = press_q;
  assign pulsoSoltura    = rel_q;
  assign pulsoLongo      = long_q;

endmodule
